// File: rtl/dmem_access.sv
// dmem_access: MEM2-stage data-memory access unit for the RV64I pipeline.
// Turns a decoded load/store into a single doubleword bus transaction. It
// stalls the pipeline until the bus acknowledges, then presents the aligned
// and extended load result on mem_rdata.
module dmem_access #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic                  mem_ren,
    input  logic                  mem_wen,
    input  logic [2:0]            funct3,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    output logic [7:0]            dmem_wstrb,
    input  logic                  dmem_ack,
    input  logic [DATA_WIDTH-1:0] dmem_rdata,
    output logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  stall,
    output logic                  done,
    output logic                  misalign
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic       accept;
    logic       legal;
    logic       aligned;
    logic       start;
    logic [1:0] size;
    logic [7:0] size_mask;

    // Captured access attributes; used when the read data returns.
    logic [1:0] size_q;
    logic       sign_q;
    logic [2:0] off_q;

    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] load_ext;

    // Decode the incoming instruction: legality, natural alignment, lane mask.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        accept    = in_valid & (mem_ren | mem_wen);
        size      = funct3[1:0];
        legal     = mem_wen ? ~funct3[2] : (funct3 != 3'b111);
        aligned   = 1'b1;
        size_mask = 8'h01;
        case (size)
            2'd0: begin aligned = 1'b1;              size_mask = 8'h01; end
            2'd1: begin aligned = ~addr[0];          size_mask = 8'h03; end
            2'd2: begin aligned = (addr[1:0] == 0);  size_mask = 8'h0F; end
            default: begin aligned = (addr[2:0] == 0); size_mask = 8'hFF; end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Next-state logic and the combinational pipeline-control outputs.
    always_comb begin
        state_nx = state;
        stall    = 1'b0;
        done     = 1'b0;
        misalign = 1'b0;
        start    = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (legal && aligned) begin
                        start    = 1'b1;
                        stall    = 1'b1;
                        state_nx = S_BUSY;
                    end else begin
                        misalign = 1'b1;
                    end
                end
            end
            S_BUSY: begin
                stall = 1'b1;
                if (dmem_ack) state_nx = S_DONE;
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Align the returned doubleword and sign- or zero-extend it to the access size.
    always_comb begin
        shifted  = dmem_rdata >> {off_q, 3'b000};
        load_ext = shifted;
        case (size_q)
            2'd0: load_ext = sign_q ? {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]}
                                    : {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
            2'd1: load_ext = sign_q ? {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]}
                                    : {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
            2'd2: load_ext = sign_q ? {{(DATA_WIDTH-32){shifted[31]}}, shifted[31:0]}
                                    : {{(DATA_WIDTH-32){1'b0}}, shifted[31:0]};
            default: load_ext = shifted;
        endcase
    end

    // Bus-side registers and the load result; bus outputs hold stable through BUSY.
    always_ff @(posedge clk) begin
        if (rst) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            dmem_wstrb <= '0;
            size_q     <= '0;
            sign_q     <= 1'b0;
            off_q      <= '0;
            mem_rdata  <= '0;
        end else begin
            if (start) begin
                dmem_req   <= 1'b1;
                dmem_we    <= mem_wen;
                dmem_addr  <= {addr[ADDR_WIDTH-1:3], 3'b000};
                dmem_wdata <= wdata << {addr[2:0], 3'b000};
                dmem_wstrb <= size_mask << addr[2:0];
                size_q     <= size;
                sign_q     <= ~funct3[2];
                off_q      <= addr[2:0];
            end
            if (state == S_BUSY && dmem_ack) begin
                dmem_req <= 1'b0;
                if (!dmem_we) mem_rdata <= load_ext;
            end
        end
    end

endmodule
